seq_fill_engine: RTL and testbench

- Parametrised successor of the register-file fill test top: generates a two-term recurrence sequence into an internal DEPTH-entry memory.
- Adds a selectable recurrence op, programmable length, a start/busy/done handshake, a sticky overflow flag and a registered read-back port.
- Sits behind the test top; drives bring-up of ALU/register-file paths; results are read back for display on `num`.

---
 rtl/seq_fill_engine.sv | 225 ++++++++++++++++++++++
 tb/tb_seq_fill_engine.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_fill_engine.sv
// seq_fill_engine
// Fills an internal DEPTH-entry memory with a two-term recurrence sequence.
// Term 0 and term 1 are the seeds; every later term is f(term k-2, term k-1)
// with f selected by mode (add, subtract, xor, add-double). A run is launched
// by start in IDLE and reports busy for its whole length, a one-cycle done
// pulse on the final write, and a sticky overflow/borrow flag.
//
// Ports:
//   clk      sole clock, all state updates on posedge
//   rst_n    synchronous active-low reset (memory contents are kept)
//   start    run request, only honoured in IDLE
//   mode     recurrence op: 00 a+b, 01 a-b, 10 a^b, 11 a+(b<<1)
//   seed0    term 0
//   seed1    term 1
//   len      number of terms, clamped to [2, DEPTH]
//   busy     run in progress
//   done     one-cycle pulse with the last write
//   ovf      sticky carry/borrow of the current or last run
//   rd_addr  read address
//   rd_data  registered read data, one cycle latency, read-before-write
module seq_fill_engine #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  seed0,
  input  logic [WIDTH-1:0]  seed1,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] TWO     = {{(ADDR_W-1){1'b0}}, 2'b10};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    W0   = 2'd1,
    W1   = 2'd2,
    RUN  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [ADDR_W:0]    lenEff_q, lenEff_d;
  logic [ADDR_W:0]    k_q, k_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH-1:0]   rdData_q;

  logic [WIDTH-1:0]   mem [DEPTH];

  logic [ADDR_W:0]    lenClamp;
  logic [WIDTH+1:0]   sumAdd;
  logic [WIDTH+1:0]   sumDbl;
  logic [WIDTH-1:0]   fRes;
  logic               fOvf;
  logic               memWe;
  logic [WIDTH-1:0]   memWdata;

  // Runs shorter than the two seeds or longer than the memory are clamped
  // so the write address never wraps.
  always_comb begin
    lenClamp = len;
    if (len < TWO) begin
      lenClamp = TWO;
    end else if (len > DEPTH_L) begin
      lenClamp = DEPTH_L;
    end
  end

  // Recurrence op. Sums are two bits wider so that both the carry of
  // a+b and anything pushed out by doubling b land in the top bits.
  always_comb begin
    sumAdd = {2'b00, a_q} + {2'b00, b_q};
    sumDbl = {2'b00, a_q} + {1'b0, b_q, 1'b0};
    fRes   = a_q ^ b_q;
    fOvf   = 1'b0;
    case (mode_q)
      2'b00: begin
        fRes = sumAdd[WIDTH-1:0];
        fOvf = sumAdd[WIDTH];
      end
      2'b01: begin
        fRes = a_q - b_q;
        fOvf = (a_q < b_q);
      end
      2'b10: begin
        fRes = a_q ^ b_q;
        fOvf = 1'b0;
      end
      default: begin
        fRes = sumDbl[WIDTH-1:0];
        fOvf = |sumDbl[WIDTH+1:WIDTH];
      end
    endcase
  end

  // Next-state logic. The seeds are captured straight into a/b on the
  // accepted start, so W0 and W1 only have to write them out. k doubles as
  // the write address in every writing state.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    a_d      = a_q;
    b_d      = b_q;
    lenEff_d = lenEff_q;
    k_d      = k_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    memWe    = 1'b0;
    memWdata = a_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = W0;
          mode_d   = mode;
          a_d      = seed0;
          b_d      = seed1;
          lenEff_d = lenClamp;
          k_d      = '0;
          ovf_d    = 1'b0;
          busy_d   = 1'b1;
        end
      end
      W0: begin
        memWe    = 1'b1;
        memWdata = a_q;
        k_d      = k_q + ONE;
        state_d  = W1;
      end
      W1: begin
        memWe    = 1'b1;
        memWdata = b_q;
        k_d      = k_q + ONE;
        if (lenEff_q > TWO) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      RUN: begin
        memWe    = 1'b1;
        memWdata = fRes;
        a_d      = b_q;
        b_d      = fRes;
        k_d      = k_q + ONE;
        if (fOvf) begin
          ovf_d = 1'b1;
        end
        if (k_q == lenEff_q - ONE) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and datapath registers; a reset mid-run simply abandons it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mode_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      lenEff_q <= '0;
      k_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      lenEff_q <= lenEff_d;
      k_q      <= k_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  // Memory array has no reset so it maps onto distributed RAM; the write
  // is suppressed during reset so an aborted run writes nothing further.
  always_ff @(posedge clk) begin
    if (rst_n && memWe) begin
      mem[k_q[ADDR_W-1:0]] <= memWdata;
    end
  end

  // Registered read; a same-edge write to the same address returns the
  // previous contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdData_q <= '0;
    end else begin
      rdData_q <= mem[rd_addr];
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign ovf     = ovf_q;
  assign rd_data = rdData_q;

endmodule

// File: tb/tb_seq_fill_engine.sv
// tb_seq_fill_engine
// Drives seq_fill_engine (WIDTH=8, ADDR_W=6) through directed and random
// runs and compares busy/done/ovf timing and memory contents against a
// reference model that computes each run's terms with plain integer
// arithmetic.
module tb_seq_fill_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] mode;
  logic [7:0] seed0;
  logic [7:0] seed1;
  logic [6:0] len;
  logic       busy;
  logic       done;
  logic       ovf;
  logic [5:0] rd_addr;
  logic [7:0] rd_data;

  int errors;
  int checks;

  int expMem [64];
  bit expValid [64];
  int oldMem [64];
  bit oldValid [64];

  seq_fill_engine #(
    .WIDTH (8),
    .ADDR_W(6)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mode   (mode),
    .seed0  (seed0),
    .seed1  (seed1),
    .len    (len),
    .busy   (busy),
    .done   (done),
    .ovf    (ovf),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // One comparison: counted, and reported on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Read one memory word through the registered port and compare it.
  task automatic readCheck(input string tag, input int addr, input int expected);
    rd_addr = 6'(addr);
    @(negedge clk);
    checkOutput(tag, 32'(rd_data), 32'(expected));
  endtask

  // Launch a run from IDLE and follow it to completion. abuse toggles start
  // and scrambles the operands while busy; hold keeps start high and returns
  // at the done cycle so the caller can chain the next run straight away.
  task automatic applyStimulus(input int m, input int s0, input int s1,
                               input int l, input bit abuse, input bit hold);
    int lenEff;
    int j;
    int a;
    int b;
    int r;
    bit ovk;
    int terms [64];
    bit ovfAt [101];

    lenEff = (l < 2) ? 2 : ((l > 64) ? 64 : l);
    terms[0] = s0 & 255;
    terms[1] = s1 & 255;
    ovfAt[0] = 1'b0;
    ovfAt[1] = 1'b0;
    ovfAt[2] = 1'b0;
    for (int k = 2; k < lenEff; k++) begin
      a = terms[k-2];
      b = terms[k-1];
      case (m & 3)
        0: begin r = a + b;     ovk = (r > 255); end
        1: begin r = a - b;     ovk = (a < b);   end
        2: begin r = a ^ b;     ovk = 1'b0;      end
        default: begin r = a + 2 * b; ovk = (r > 255); end
      endcase
      terms[k] = r & 255;
      ovfAt[k+1] = ovfAt[k] | ovk;
    end
    for (int k = lenEff + 1; k <= 100; k++) begin
      ovfAt[k] = ovfAt[lenEff];
    end

    oldMem = expMem;
    oldValid = expValid;
    for (int k = 0; k < lenEff; k++) begin
      expMem[k] = terms[k];
      expValid[k] = 1'b1;
    end

    mode  = 2'(m);
    seed0 = 8'(s0);
    seed1 = 8'(s1);
    len   = 7'(l);
    start = 1'b1;
    @(negedge clk);

    j = 0;
    while (busy === 1'b1 && j < 100) begin
      if (j > 0 && oldValid[j-1]) begin
        checkOutput("rd_before_wr", 32'(rd_data), 32'(oldMem[j-1]));
      end
      checkOutput("done_low_run", 32'(done), 32'd0);
      checkOutput("ovf_run", 32'(ovf), 32'(ovfAt[j]));
      rd_addr = 6'(j);
      if (abuse) begin
        start = 1'($urandom_range(0, 1));
        mode  = 2'($urandom_range(0, 3));
        seed0 = 8'($urandom_range(0, 255));
        seed1 = 8'($urandom_range(0, 255));
        len   = 7'($urandom_range(0, 127));
      end else begin
        start = hold;
      end
      @(negedge clk);
      j++;
    end

    if (j > 0 && j <= 64 && oldValid[j-1]) begin
      checkOutput("rd_before_wr_last", 32'(rd_data), 32'(oldMem[j-1]));
    end
    checkOutput("busy_cycles", 32'(j), 32'(lenEff));
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("ovf_final", 32'(ovf), 32'(ovfAt[lenEff]));

    if (!hold) begin
      start = 1'b0;
      @(negedge clk);
      checkOutput("done_clear", 32'(done), 32'd0);
      checkOutput("busy_idle", 32'(busy), 32'd0);
      for (int i = 0; i <= ((lenEff < 64) ? lenEff : 63); i++) begin
        if (expValid[i]) begin
          readCheck("mem_readback", i, expMem[i]);
        end
      end
    end
  endtask

  initial begin
    int rs0;
    errors  = 0;
    checks  = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    mode    = 2'd0;
    seed0   = 8'd0;
    seed1   = 8'd0;
    len     = 7'd0;
    rd_addr = 6'd0;
    for (int i = 0; i < 64; i++) begin
      expMem[i] = 0;
      expValid[i] = 1'b0;
    end

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_ovf", 32'(ovf), 32'd0);
    checkOutput("reset_rd_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fibonacci, no overflow.
    $display("[TB] fibonacci len=10");
    applyStimulus(0, 0, 1, 10, 1'b0, 1'b0);
    readCheck("fib_mem9", 9, 34);

    // Fibonacci past 8 bits, sets ovf; next start clears it.
    $display("[TB] fibonacci len=16 overflow");
    applyStimulus(0, 0, 1, 16, 1'b0, 1'b0);
    readCheck("ovf_mem13", 13, 233);
    readCheck("ovf_mem14", 14, 121);
    readCheck("ovf_mem15", 15, 98);

    // Subtract with borrow on the last term, then xor.
    $display("[TB] sub and xor modes");
    applyStimulus(1, 5, 3, 8, 1'b0, 1'b0);
    readCheck("sub_mem7", 7, 255);
    applyStimulus(2, 1, 2, 6, 1'b0, 1'b0);
    readCheck("xor_mem5", 5, 3);

    // Length clamps at both ends.
    $display("[TB] length clamps");
    applyStimulus(0, 7, 9, 0, 1'b0, 1'b0);
    rs0 = int'($urandom_range(0, 255));
    applyStimulus(3, rs0, int'($urandom_range(0, 255)), 69, 1'b0, 1'b0);
    readCheck("clamp_mem0", 0, rs0);

    // start pulses with changing operands while busy.
    $display("[TB] start abuse during run");
    applyStimulus(0, 3, 4, 30, 1'b1, 1'b0);

    // start held high through done chains straight into a second run.
    $display("[TB] start held through done");
    applyStimulus(1, 200, 7, 12, 1'b0, 1'b1);
    applyStimulus(3, 9, 100, 5, 1'b0, 1'b0);

    // Reset in the middle of a len=20 run, asserted for edge E4.
    $display("[TB] reset mid-run");
    mode  = 2'd0;
    seed0 = 8'd0;
    seed1 = 8'd1;
    len   = 7'd20;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_ovf", 32'(ovf), 32'd0);
    checkOutput("midrst_rd_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    expMem[0] = 0; expValid[0] = 1'b1;
    expMem[1] = 1; expValid[1] = 1'b1;
    expMem[2] = 1; expValid[2] = 1'b1;
    readCheck("midrst_mem0", 0, 0);
    readCheck("midrst_mem1", 1, 1);
    readCheck("midrst_mem2", 2, 1);
    if (expValid[3]) begin
      readCheck("midrst_mem3_kept", 3, expMem[3]);
    end

    // Random runs, including clamp lengths and abuse.
    $display("[TB] random runs");
    for (int n = 0; n < 12; n++) begin
      applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 70)),
                    1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
